// File: rtl/seg7_frame_decoder.sv
// seg7_frame_decoder: accepts a frame of eight active-low 7-segment codes,
// latches it, and streams one decoded ASCII character per digit over a
// valid/ready handshake. The order is digit 7->0 (MSB_FIRST=1) or 0->7.
// Optional feature: define SEG_ERR_COUNT_EN to build a saturating counter
// of accepted "?" (unrecognised) characters. Otherwise err_count is tied to 0.
module seg7_frame_decoder #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        CLOCK_50,
  input  logic        KEY1,
  input  logic [55:0] seg_bus,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic [7:0]  char_data,
  output logic        char_valid,
  input  logic        char_ready,
  output logic [2:0]  digit_idx,
  output logic        frame_done,
  output logic [7:0]  err_count
);

  localparam logic [2:0] FIRST_IDX = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] LAST_IDX  = MSB_FIRST ? 3'd0 : 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_n;
  logic [55:0] frame_q, frame_n;
  logic [2:0]  idx_q, idx_n;
  logic [7:0]  data_q, data_n;
  logic        valid_q, valid_n;
  logic [2:0]  idx_step;

  function automatic logic [6:0] digit_code(input logic [55:0] f, input logic [2:0] i);
    return f[7*int'(i) +: 7];
  endfunction

  function automatic logic [7:0] decode(input logic [6:0] code);
    case (code)
      7'b0001001: return 8'h48;  // H
      7'b0000110: return 8'h45;  // E
      7'b1000111: return 8'h4C;  // L
      7'b1000000: return 8'h4F;  // O
      7'b0000000,
      7'b1111111: return 8'h20;  // blank
      default:    return 8'h3F;  // ?
    endcase
  endfunction

  assign idx_step = MSB_FIRST ? (idx_q - 3'd1) : (idx_q + 3'd1);

  // State register and registered character outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY1) begin
      state_q <= IDLE;
      frame_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_n;
      frame_q <= frame_n;
      idx_q   <= idx_n;
      data_q  <= data_n;
      valid_q <= valid_n;
    end
  end

  // Next state: the following character is decoded in the same cycle the
  // current one is accepted, so the stream has no bubbles.
  always_comb begin
    state_n = state_q;
    frame_n = frame_q;
    idx_n   = idx_q;
    data_n  = data_q;
    valid_n = valid_q;
    case (state_q)
      IDLE: begin
        if (frame_valid) begin
          frame_n = seg_bus;
          idx_n   = FIRST_IDX;
          data_n  = decode(digit_code(seg_bus, FIRST_IDX));
          valid_n = 1'b1;
          state_n = EMIT;
        end
      end
      EMIT: begin
        if (char_ready) begin
          if (idx_q == LAST_IDX) begin
            valid_n = 1'b0;
            state_n = DONE;
          end else begin
            idx_n  = idx_step;
            data_n = decode(digit_code(frame_q, idx_step));
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  assign frame_ready = (state_q == IDLE);
  assign frame_done  = (state_q == DONE);
  assign char_data   = data_q;
  assign char_valid  = valid_q;
  assign digit_idx   = idx_q;

`ifdef SEG_ERR_COUNT_EN
  logic [7:0] err_q;

  // Count accepted "?" characters, saturating at 255. Only reset clears the count.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY1) begin
      err_q <= '0;
    end else if (valid_q && char_ready && (data_q == 8'h3F) && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed self-checking bench for seg7_frame_decoder. One MSB-first and one
// LSB-first instance share all inputs and run in lockstep.
module tb_seg7_frame_decoder;

  logic        CLOCK_50 = 1'b0;
  logic        KEY1;
  logic [55:0] seg_bus;
  logic        frame_valid;
  logic        char_ready;

  logic        m_frame_ready, m_char_valid, m_frame_done;
  logic [7:0]  m_char_data, m_err_count;
  logic [2:0]  m_digit_idx;
  logic        l_frame_ready, l_char_valid, l_frame_done;
  logic [7:0]  l_char_data, l_err_count;
  logic [2:0]  l_digit_idx;

  int checks   = 0;
  int failures = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  seg7_frame_decoder #(.MSB_FIRST(1'b1)) u_msb (
    .CLOCK_50   (CLOCK_50),
    .KEY1       (KEY1),
    .seg_bus    (seg_bus),
    .frame_valid(frame_valid),
    .frame_ready(m_frame_ready),
    .char_data  (m_char_data),
    .char_valid (m_char_valid),
    .char_ready (char_ready),
    .digit_idx  (m_digit_idx),
    .frame_done (m_frame_done),
    .err_count  (m_err_count)
  );

  seg7_frame_decoder #(.MSB_FIRST(1'b0)) u_lsb (
    .CLOCK_50   (CLOCK_50),
    .KEY1       (KEY1),
    .seg_bus    (seg_bus),
    .frame_valid(frame_valid),
    .frame_ready(l_frame_ready),
    .char_data  (l_char_data),
    .char_valid (l_char_valid),
    .char_ready (char_ready),
    .digit_idx  (l_digit_idx),
    .frame_done (l_frame_done),
    .err_count  (l_err_count)
  );

  task automatic tick();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ed holds the expected character for digit n at [8n+7:8n].
  task automatic run_frame(input logic [55:0] f, input logic [63:0] ed,
                           input int stall_k, input int rst_k, input int junk_k);
    logic [7:0] m_exp, l_exp;
    seg_bus     = f;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    seg_bus     = ~f;
    for (int k = 0; k < 8; k++) begin
      m_exp = ed[8*(7-k) +: 8];
      l_exp = ed[8*k +: 8];
      if (k == rst_k) begin
        KEY1 = 1'b0;
        tick();
        KEY1 = 1'b1;
        chk("rst_char_valid", {7'd0, m_char_valid}, 8'd0);
        chk("rst_frame_ready", {7'd0, m_frame_ready}, 8'd1);
        chk("rst_frame_done", {7'd0, m_frame_done}, 8'd0);
        chk("rst_err_count", m_err_count, 8'd0);
        for (int j = 0; j < 10; j++) begin
          tick();
          chk("rst_no_done", {7'd0, m_frame_done}, 8'd0);
        end
        return;
      end
      if (k == stall_k) begin
        char_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          chk("stall_m_data", m_char_data, m_exp);
          chk("stall_m_valid", {7'd0, m_char_valid}, 8'd1);
          chk("stall_m_idx", {5'd0, m_digit_idx}, 8'(7 - k));
          chk("stall_l_data", l_char_data, l_exp);
          tick();
        end
        char_ready = 1'b1;
      end
      chk("m_valid", {7'd0, m_char_valid}, 8'd1);
      chk("m_data", m_char_data, m_exp);
      chk("m_idx", {5'd0, m_digit_idx}, 8'(7 - k));
      chk("l_data", l_char_data, l_exp);
      chk("l_idx", {5'd0, l_digit_idx}, 8'(k));
      chk("m_frame_ready_busy", {7'd0, m_frame_ready}, 8'd0);
      chk("m_done_early", {7'd0, m_frame_done}, 8'd0);
      if (k == junk_k) begin
        frame_valid = 1'b1;
        seg_bus     = {8{7'h2A}};
        tick();
        frame_valid = 1'b0;
      end else begin
        tick();
      end
    end
    chk("m_frame_done", {7'd0, m_frame_done}, 8'd1);
    chk("l_frame_done", {7'd0, l_frame_done}, 8'd1);
    chk("m_valid_done", {7'd0, m_char_valid}, 8'd0);
    chk("m_ready_done", {7'd0, m_frame_ready}, 8'd0);
    tick();
    chk("m_done_clear", {7'd0, m_frame_done}, 8'd0);
    chk("m_ready_idle", {7'd0, m_frame_ready}, 8'd1);
    chk("l_ready_idle", {7'd0, l_frame_ready}, 8'd1);
  endtask

  localparam logic [55:0] HELLO_F  = {7'h7F, 7'h00, 7'h7F, 7'h09, 7'h06, 7'h47, 7'h47, 7'h40};
  localparam logic [63:0] HELLO_E  = {8'h20, 8'h20, 8'h20, 8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
  localparam logic [55:0] ERR3_F   = {7'h7F, 7'h00, 7'h7F, 7'h09, 7'h2A, 7'h47, 7'h47, 7'h40};
  localparam logic [63:0] ERR3_E   = {8'h20, 8'h20, 8'h20, 8'h48, 8'h3F, 8'h4C, 8'h4C, 8'h4F};
  localparam logic [55:0] ALLBAD_F = {8{7'h2A}};
  localparam logic [63:0] ALLBAD_E = {8{8'h3F}};

  initial begin
    KEY1        = 1'b0;
    seg_bus     = '0;
    frame_valid = 1'b0;
    char_ready  = 1'b1;
    @(negedge CLOCK_50);
    tick();
    tick();
    chk("reset_frame_ready", {7'd0, m_frame_ready}, 8'd1);
    chk("reset_char_valid", {7'd0, m_char_valid}, 8'd0);
    chk("reset_char_data", m_char_data, 8'h00);
    chk("reset_digit_idx", {5'd0, m_digit_idx}, 8'd0);
    chk("reset_frame_done", {7'd0, m_frame_done}, 8'd0);
    chk("reset_err_count", m_err_count, 8'd0);
    KEY1 = 1'b1;
    tick();

    // Plain HELLO frame, full-rate sink, plus an ignored frame offer mid-emit
    run_frame(HELLO_F, HELLO_E, -1, -1, 2);

    // Sink stalls for 5 cycles while the MSB-first stream is at digit 4
    run_frame(HELLO_F, HELLO_E, 3, -1, -1);

    // Unrecognised code in digit 3
    run_frame(ERR3_F, ERR3_E, -1, -1, -1);
`ifdef SEG_ERR_COUNT_EN
    chk("err_count_one", m_err_count, 8'd1);
`else
    chk("err_count_off", m_err_count, 8'd0);
`endif

    // 38 all-bad frames: 304 further "?" characters saturate the counter
    run_frame(ALLBAD_F, ALLBAD_E, -1, -1, -1);
`ifdef SEG_ERR_COUNT_EN
    chk("err_count_nine", m_err_count, 8'd9);
`else
    chk("err_count_off_9", m_err_count, 8'd0);
`endif
    for (int n = 1; n < 38; n++) run_frame(ALLBAD_F, ALLBAD_E, -1, -1, -1);
`ifdef SEG_ERR_COUNT_EN
    chk("err_count_sat", m_err_count, 8'd255);
    chk("err_count_sat_l", l_err_count, 8'd255);
`else
    chk("err_count_off_sat", m_err_count, 8'd0);
    chk("err_count_off_sat_l", l_err_count, 8'd0);
`endif

    // Reset while the MSB-first stream presents digit 2 (k=5)
    run_frame(HELLO_F, HELLO_E, -1, 5, -1);

    // Decoder is usable again after the abandoned frame
    run_frame(HELLO_F, HELLO_E, -1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
